// File: rtl/bus_arbiter.sv
// bus_arbiter: two-port (CPU / DMA) round-robin arbiter in front of a single
// synchronous-write RAM with combinational read data.
// Optional feature: define BUS_ARB_LOCK_EN to add the c_lock port, which lets
// the CPU keep the bus across back-to-back transactions (read-modify-write).

module bus_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic        c_byte,
  input  logic [15:0] c_addr,
  input  logic [15:0] c_wdata,
  output logic        c_ack,
  output logic [15:0] c_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_byte,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
`ifdef BUS_ARB_LOCK_EN
  input  logic        c_lock,
`endif
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic        mem_byte,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,
  output logic        busy
);

  localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [2:0] cnt;
  logic       owner_dma;
  logic       last_dma;
  logic       lat_we;
  logic       grant_dma;
  logic       lock_grant;
  logic       final_cycle;

`ifdef BUS_ARB_LOCK_EN
  logic lock_pend;
  assign lock_grant = lock_pend & c_req;
`else
  assign lock_grant = 1'b0;
`endif

  assign final_cycle = (cnt == LAST_CNT);

  // Pick the winner for an IDLE cycle: a pending CPU lock first, then
  // round-robin on contention, otherwise whichever port is requesting.
  always_comb begin
    grant_dma = 1'b0;
    if (lock_grant) begin
      grant_dma = 1'b0;
    end else if (c_req && d_req) begin
      grant_dma = ~last_dma;
    end else begin
      grant_dma = d_req;
    end
  end

  // Next-state logic plus the strobes that depend only on the current state.
  always_comb begin
    state_next = state;
    c_ack      = 1'b0;
    d_ack      = 1'b0;
    mem_we     = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (c_req || d_req) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (final_cycle) begin
          state_next = DONE;
          mem_we     = lat_we;
        end
      end
      DONE: begin
        state_next = IDLE;
        c_ack      = ~owner_dma;
        d_ack      = owner_dma;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Transaction latch, wait counter, arbitration history and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= 3'd0;
      owner_dma <= 1'b0;
      last_dma  <= 1'b1;
      lat_we    <= 1'b0;
      mem_addr  <= 16'd0;
      mem_byte  <= 1'b0;
      mem_din   <= 16'd0;
      c_rdata   <= 16'd0;
      d_rdata   <= 16'd0;
`ifdef BUS_ARB_LOCK_EN
      lock_pend <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef BUS_ARB_LOCK_EN
          lock_pend <= 1'b0;
`endif
          if (c_req || d_req) begin
            cnt       <= 3'd0;
            owner_dma <= grant_dma;
            last_dma  <= grant_dma;
            if (grant_dma) begin
              lat_we   <= d_we;
              mem_addr <= d_addr;
              mem_byte <= d_byte;
              mem_din  <= d_wdata;
            end else begin
              lat_we   <= c_we;
              mem_addr <= c_addr;
              mem_byte <= c_byte;
              mem_din  <= c_wdata;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt + 3'd1;
          if (final_cycle && !lat_we) begin
            if (owner_dma) begin
              d_rdata <= mem_dout;
            end else begin
              c_rdata <= mem_dout;
            end
          end
        end
        DONE: begin
`ifdef BUS_ARB_LOCK_EN
          lock_pend <= ~owner_dma & c_lock;
`endif
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: drives two arbiter instances (WAIT_CYCLES = 1 and 3) with the
// same request stream; each has its own RAM and a transaction-level model.
// Build with BUS_ARB_LOCK_EN defined to also exercise the CPU lock.

module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_we, c_byte;
  logic [15:0] c_addr, c_wdata;
  logic        d_req, d_we, d_byte;
  logic [15:0] d_addr, d_wdata;
`ifdef BUS_ARB_LOCK_EN
  logic        c_lock;
`endif

  logic        o_cack [2];
  logic        o_dack [2];
  logic [15:0] o_crd  [2];
  logic [15:0] o_drd  [2];
  logic [15:0] o_maddr[2];
  logic        o_mwe  [2];
  logic        o_mbyte[2];
  logic [15:0] o_mdin [2];
  logic [15:0] mdout  [2];
  logic        o_busy [2];

  logic [15:0] ram [2][1024];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  bit checking = 1'b0;

  // Transaction-level model state, one slot per instance.
  int          W [2] = '{1, 3};
  bit          m_act [2];
  int          m_rel [2];
  bit          m_own [2];
  bit          m_last_dma [2];
  bit          m_lock [2];
  bit          m_we [2];
  bit          m_byte [2];
  logic [15:0] m_addr [2];
  logic [15:0] m_din [2];
  logic [15:0] m_crd [2];
  logic [15:0] m_drd [2];
  logic [15:0] mram [2][1024];

  // Event log for the hand-computed expectations.
  int          we_cnt [2];
  int          we_rel [2];
  bit          we_byte [2];
  logic [15:0] we_din [2];
  int          cack_n [2];
  int          dack_n [2];
  int          cack_last [2];
  int          dack_last [2];
  int          ack0_rel[$];
  bit          ack0_dma[$];

  bus_arbiter #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_byte(c_byte), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(o_cack[0]), .c_rdata(o_crd[0]),
    .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(o_dack[0]), .d_rdata(o_drd[0]),
`ifdef BUS_ARB_LOCK_EN
    .c_lock(c_lock),
`endif
    .mem_addr(o_maddr[0]), .mem_we(o_mwe[0]), .mem_byte(o_mbyte[0]), .mem_din(o_mdin[0]),
    .mem_dout(mdout[0]), .busy(o_busy[0])
  );

  bus_arbiter #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_byte(c_byte), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(o_cack[1]), .c_rdata(o_crd[1]),
    .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(o_dack[1]), .d_rdata(o_drd[1]),
`ifdef BUS_ARB_LOCK_EN
    .c_lock(c_lock),
`endif
    .mem_addr(o_maddr[1]), .mem_we(o_mwe[1]), .mem_byte(o_mbyte[1]), .mem_din(o_mdin[1]),
    .mem_dout(mdout[1]), .busy(o_busy[1])
  );

  assign mdout[0] = ram[0][o_maddr[0][9:0]];
  assign mdout[1] = ram[1][o_maddr[1][9:0]];

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle index used to time events relative to a test's start.
  always @(posedge clk) cyc <= cyc + 1;

  // RAM write port for each instance.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (o_mwe[i]) ram[i][o_maddr[i][9:0]] <= o_mdin[i];
    end
  end

  task automatic check_value(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s[dut%0d] at cycle %0d: got %h expected %h", name, idx, cyc, act, exp);
    end
  endtask

  // Every cycle: compare each instance against its model, log events, then
  // advance the model across the coming clock edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit e_busy, e_we, e_cack, e_dack, wd;
      e_busy = m_act[i];
      e_we   = m_act[i] && (m_rel[i] == W[i]) && m_we[i];
      e_cack = m_act[i] && (m_rel[i] == W[i] + 1) && !m_own[i];
      e_dack = m_act[i] && (m_rel[i] == W[i] + 1) && m_own[i];
      if (checking) begin
        check_value("busy",     i, 32'(o_busy[i]),  32'(e_busy));
        check_value("mem_we",   i, 32'(o_mwe[i]),   32'(e_we));
        check_value("c_ack",    i, 32'(o_cack[i]),  32'(e_cack));
        check_value("d_ack",    i, 32'(o_dack[i]),  32'(e_dack));
        check_value("mem_addr", i, 32'(o_maddr[i]), 32'(m_addr[i]));
        check_value("mem_byte", i, 32'(o_mbyte[i]), 32'(m_byte[i]));
        check_value("mem_din",  i, 32'(o_mdin[i]),  32'(m_din[i]));
        check_value("c_rdata",  i, 32'(o_crd[i]),   32'(m_crd[i]));
        check_value("d_rdata",  i, 32'(o_drd[i]),   32'(m_drd[i]));
        if (o_mwe[i] === 1'b1) begin
          we_cnt[i]++;
          we_rel[i]  = cyc - t0;
          we_byte[i] = o_mbyte[i];
          we_din[i]  = o_mdin[i];
        end
        if (o_cack[i] === 1'b1) begin
          cack_n[i]++;
          cack_last[i] = cyc - t0;
          if (i == 0) begin ack0_rel.push_back(cyc - t0); ack0_dma.push_back(1'b0); end
        end
        if (o_dack[i] === 1'b1) begin
          dack_n[i]++;
          dack_last[i] = cyc - t0;
          if (i == 0) begin ack0_rel.push_back(cyc - t0); ack0_dma.push_back(1'b1); end
        end
      end
      if (e_we) mram[i][m_addr[i][9:0]] = m_din[i];
      if (reset) begin
        m_act[i] = 1'b0;  m_rel[i] = 0;  m_own[i] = 1'b0;  m_last_dma[i] = 1'b1;
        m_lock[i] = 1'b0; m_we[i] = 1'b0; m_byte[i] = 1'b0;
        m_addr[i] = 16'd0; m_din[i] = 16'd0; m_crd[i] = 16'd0; m_drd[i] = 16'd0;
      end else if (m_act[i]) begin
        if (m_rel[i] == W[i] && !m_we[i]) begin
          if (m_own[i]) m_drd[i] = mram[i][m_addr[i][9:0]];
          else          m_crd[i] = mram[i][m_addr[i][9:0]];
        end
        if (m_rel[i] == W[i] + 1) begin
`ifdef BUS_ARB_LOCK_EN
          m_lock[i] = !m_own[i] && c_lock;
`endif
          m_act[i] = 1'b0;
        end else begin
          m_rel[i]++;
        end
      end else begin
        if (c_req || d_req) begin
          if (m_lock[i] && c_req)  wd = 1'b0;
          else if (c_req && d_req) wd = !m_last_dma[i];
          else                     wd = d_req;
          m_own[i] = wd;  m_last_dma[i] = wd;
          m_we[i]   = wd ? d_we    : c_we;
          m_byte[i] = wd ? d_byte  : c_byte;
          m_addr[i] = wd ? d_addr  : c_addr;
          m_din[i]  = wd ? d_wdata : c_wdata;
          m_act[i] = 1'b1;  m_rel[i] = 1;
        end
        m_lock[i] = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    for (int i = 0; i < 2; i++) begin
      we_cnt[i] = 0; we_rel[i] = -1; we_byte[i] = 1'b0; we_din[i] = 16'd0;
      cack_n[i] = 0; dack_n[i] = 0; cack_last[i] = -1; dack_last[i] = -1;
    end
    ack0_rel.delete();
    ack0_dma.delete();
    t0 = cyc;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic idle_inputs();
    c_req = 1'b0; c_we = 1'b0; c_byte = 1'b0; c_addr = 16'd0; c_wdata = 16'd0;
    d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0; d_addr = 16'd0; d_wdata = 16'd0;
  endtask

  logic [31:0] pat_c, pat_d, pat_w;

  initial begin
    reset = 1'b1;
    idle_inputs();
`ifdef BUS_ARB_LOCK_EN
    c_lock = 1'b0;
`endif
    for (int j = 0; j < 1024; j++) begin
      ram[0][j] = 16'(j * 37 + 5);
      ram[1][j] = 16'(j * 37 + 5);
    end
    ram[0][512] = 16'o012345;
    ram[1][512] = 16'o012345;
    for (int j = 0; j < 1024; j++) begin
      mram[0][j] = ram[0][j];
      mram[1][j] = ram[1][j];
    end
    tick();
    do_reset();
    checking = 1'b1;

    // Reset state pinned to literals.
    for (int i = 0; i < 2; i++) begin
      check_value("rst_busy",     i, 32'(o_busy[i]),  32'd0);
      check_value("rst_mem_addr", i, 32'(o_maddr[i]), 32'd0);
      check_value("rst_c_rdata",  i, 32'(o_crd[i]),   32'd0);
      check_value("rst_d_rdata",  i, 32'(o_drd[i]),   32'd0);
    end

    // CPU read of 001000 returning 012345.
    clear_log();
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'o001000;
    tick();
    idle_inputs();
    repeat (6) tick();
    check_value("rd_ack_cycle", 0, 32'(cack_last[0]), 32'd2);
    check_value("rd_ack_cycle", 1, 32'(cack_last[1]), 32'd4);
    check_value("rd_data",      0, 32'(o_crd[0]),     32'o012345);
    check_value("rd_no_we",     0, 32'(we_cnt[0]),    32'd0);
    check_value("rd_no_we",     1, 32'(we_cnt[1]),    32'd0);

    // Both ports held high after reset: CPU, DMA, CPU at cycles 2, 5, 8.
    do_reset();
    clear_log();
    c_req = 1'b1; c_addr = 16'o000100;
    d_req = 1'b1; d_addr = 16'o000200;
    repeat (9) tick();
    idle_inputs();
    repeat (8) tick();
    check_value("rr_ack_count", 0, 32'(ack0_rel.size()), 32'd3);
    if (ack0_rel.size() >= 3) begin
      check_value("rr_ack0_cycle", 0, 32'(ack0_rel[0]), 32'd2);
      check_value("rr_ack0_dma",   0, 32'(ack0_dma[0]), 32'd0);
      check_value("rr_ack1_cycle", 0, 32'(ack0_rel[1]), 32'd5);
      check_value("rr_ack1_dma",   0, 32'(ack0_dma[1]), 32'd1);
      check_value("rr_ack2_cycle", 0, 32'(ack0_rel[2]), 32'd8);
      check_value("rr_ack2_dma",   0, 32'(ack0_dma[2]), 32'd0);
    end

    // DMA byte write of 0377 to 000777.
    clear_log();
    d_req = 1'b1; d_we = 1'b1; d_byte = 1'b1; d_addr = 16'o000777; d_wdata = 16'o000377;
    tick();
    idle_inputs();
    repeat (7) tick();
    check_value("wr_we_count", 1, 32'(we_cnt[1]),    32'd1);
    check_value("wr_we_cycle", 1, 32'(we_rel[1]),    32'd3);
    check_value("wr_we_byte",  1, 32'(we_byte[1]),   32'd1);
    check_value("wr_we_din",   1, 32'(we_din[1]),    32'o000377);
    check_value("wr_ack",      1, 32'(dack_last[1]), 32'd4);
    check_value("wr_we_cycle", 0, 32'(we_rel[0]),    32'd1);
    check_value("wr_ack",      0, 32'(dack_last[0]), 32'd2);

    // Reset in the 2nd ACCESS cycle of a WAIT_CYCLES=3 write.
    clear_log();
    c_req = 1'b1; c_we = 1'b1; c_addr = 16'o000100; c_wdata = 16'o000055;
    tick();
    idle_inputs();
    tick();
    do_reset();
    check_value("abort_busy",     1, 32'(o_busy[1]),  32'd0);
    check_value("abort_mem_addr", 1, 32'(o_maddr[1]), 32'd0);
    repeat (6) tick();
    check_value("abort_no_we",  1, 32'(we_cnt[1]), 32'd0);
    check_value("abort_no_ack", 1, 32'(cack_n[1] + dack_n[1]), 32'd0);

    // Mixed traffic from fixed bit patterns.
    pat_c = 32'hB5E3_6C9D;
    pat_d = 32'h6F1A_D3B7;
    pat_w = 32'h3C5A_9E21;
    for (int k = 0; k < 30; k++) begin
      c_req = pat_c[k];  d_req = pat_d[k];
      c_we  = pat_w[k];  d_we  = pat_w[k + 1];
      c_byte = pat_d[k + 1]; d_byte = pat_c[k + 1];
      c_addr = 16'(k * 3 + 500);  d_addr = 16'(k * 5 + 490);
      c_wdata = 16'(k * 111 + 7); d_wdata = 16'(k * 97 + 3);
      tick();
    end
    idle_inputs();
    repeat (8) tick();

`ifdef BUS_ARB_LOCK_EN
    // Locked CPU keeps the bus: two CPU acks before any DMA ack.
    do_reset();
    clear_log();
    c_lock = 1'b1;
    c_req = 1'b1; c_addr = 16'o000300;
    d_req = 1'b1; d_addr = 16'o000400;
    repeat (7) tick();
    idle_inputs();
    c_lock = 1'b0;
    repeat (8) tick();
    check_value("lock_ack_count", 0, 32'(ack0_rel.size() >= 2), 32'd1);
    if (ack0_rel.size() >= 2) begin
      check_value("lock_ack0_cycle", 0, 32'(ack0_rel[0]), 32'd2);
      check_value("lock_ack0_dma",   0, 32'(ack0_dma[0]), 32'd0);
      check_value("lock_ack1_cycle", 0, 32'(ack0_rel[1]), 32'd5);
      check_value("lock_ack1_dma",   0, 32'(ack0_dma[1]), 32'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
